// File: rtl/lrf_out_stage.sv
// lrf_out_stage: output stage behind the LRF fusion datapath.
// Counts fused beats into frames and tracks the frame index inside each fusion
// group. Only output frames are forwarded: the last frame of a group, or every
// frame when passthrough is latched at frame start. Forwarded beats go through
// a show-ahead FIFO to an AXI-Stream master, tagged with tlast on the final
// beat of each image.
//
// Ports:
//   s_axis_aclk      clock
//   s_axis_areset    asynchronous active-high reset
//   in_valid/in_data fused beat from the fusion stage
//   in_ready         stage can accept a beat this cycle
//   cfg_passthrough  forward every frame (sampled on the first beat of a frame)
//   m_axis_*         AXI-Stream master (tdata/tvalid/tready/tlast)
//   out_frame_done   one-cycle pulse after the tlast beat handshakes
//   frame_idx        index within the fusion group of the frame being received
module lrf_out_stage #(
    parameter int unsigned PIXELS_PER_BEAT = 16,
    parameter int unsigned IMAGE_DIM       = 512,
    parameter int unsigned N_FUSE_COUNT    = 4,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_areset,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    input  logic                    cfg_passthrough,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    out_frame_done,
    output logic [N_FUSE_COUNT-1:0] frame_idx
);

    localparam int unsigned BEATS      = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned LAST_FRAME = (1 << N_FUSE_COUNT) - 1;

    // Frame tracking
    logic [BEAT_W-1:0]       r_beat_cnt;
    logic [N_FUSE_COUNT-1:0] r_frame_idx;
    logic                    r_mode;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0]   r_mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   r_mem_last;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_done;

    logic w_first_beat;
    logic w_last_beat;
    logic w_mode;
    logic w_out_frame;
    logic w_full;
    logic w_ready;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_not_empty;

    // On the first beat the latch has not captured yet, so the live config
    // decides the type of the frame that is about to start.
    assign w_first_beat = (r_beat_cnt == '0);
    assign w_last_beat  = (r_beat_cnt == BEAT_W'(BEATS - 1));
    assign w_mode       = w_first_beat ? cfg_passthrough : r_mode;
    assign w_out_frame  = w_mode || (r_frame_idx == N_FUSE_COUNT'(LAST_FRAME));

    // Ready uses the registered count only: no bypass on a same-cycle pop.
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_ready     = !w_out_frame || !w_full;
    assign w_accept    = in_valid && w_ready;
    assign w_push      = w_accept && w_out_frame;
    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty && m_axis_tready;

    assign in_ready       = w_ready;
    assign m_axis_tvalid  = w_not_empty;
    assign m_axis_tdata   = w_not_empty ? r_mem_data[r_rd_ptr] : '0;
    assign m_axis_tlast   = w_not_empty ? r_mem_last[r_rd_ptr] : 1'b0;
    assign out_frame_done = r_done;
    assign frame_idx      = r_frame_idx;

    // Beat counter, group frame index and per-frame mode latch
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_beat_cnt  <= '0;
            r_frame_idx <= '0;
            r_mode      <= 1'b0;
        end else if (w_accept) begin
            if (w_first_beat) begin
                r_mode <= cfg_passthrough;
            end
            if (w_last_beat) begin
                r_beat_cnt  <= '0;
                r_frame_idx <= r_frame_idx + N_FUSE_COUNT'(1);
            end else begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

    // FIFO storage; the tag marks the final beat of an image
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
            end
            r_mem_last <= '0;
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_last[r_wr_ptr] <= w_last_beat;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame-done pulse, one cycle after the tlast handshake
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_pop && r_mem_last[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_lrf_out_stage.sv
// tb_lrf_out_stage: directed + random bench for lrf_out_stage using a small
// frame configuration (4 beats per image, 2 frames per group, 4-entry FIFO).
// A queue-based reference model predicts every output on each falling edge.
module tb_lrf_out_stage;

    localparam int unsigned PPB   = 4;
    localparam int unsigned DIM   = 4;
    localparam int unsigned NF    = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 8 * PPB;
    localparam int unsigned BEATS = DIM * DIM / PPB;
    localparam int unsigned NFR   = 1 << NF;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          cfg_passthrough;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          done;
    logic [NF-1:0] frame_idx;

    int n_cmp;
    int n_bad;
    int done_seen;

    // Reference model state
    int            m_beat;
    int            m_fidx;
    bit            m_mode;
    bit            m_done;
    logic [DW:0]   m_q[$];

    lrf_out_stage #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (DIM),
        .N_FUSE_COUNT    (NF),
        .FIFO_DEPTH      (DEPTH),
        .DATA_WIDTH      (DW)
    ) dut (
        .s_axis_aclk     (clk),
        .s_axis_areset   (rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .cfg_passthrough (cfg_passthrough),
        .m_axis_tdata    (tdata),
        .m_axis_tvalid   (tvalid),
        .m_axis_tready   (tready),
        .m_axis_tlast    (tlast),
        .out_frame_done  (done),
        .frame_idx       (frame_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model, then advance the model by the
    // handshakes that the next rising edge will perform.
    task automatic model_step();
        bit          outf;
        bit          rdy;
        bit          acc;
        bit          pop;
        logic [DW:0] head;
        if (rst) begin
            m_beat = 0;
            m_fidx = 0;
            m_mode = 1'b0;
            m_done = 1'b0;
            m_q.delete();
        end
        outf = (((m_beat == 0) ? cfg_passthrough : m_mode) == 1'b1) || (m_fidx == NFR - 1);
        rdy  = !outf || (m_q.size() < DEPTH);
        head = (m_q.size() != 0) ? m_q[0] : '0;
        check("in_ready",  64'(in_ready),  64'(rdy));
        check("tvalid",    64'(tvalid),    64'(m_q.size() != 0));
        check("tdata",     64'(tdata),     64'(head[DW-1:0]));
        check("tlast",     64'(tlast),     64'(head[DW]));
        check("done",      64'(done),      64'(m_done));
        check("frame_idx", 64'(frame_idx), 64'(m_fidx));
        if (done) done_seen++;
        if (!rst) begin
            acc    = in_valid && rdy;
            pop    = (m_q.size() != 0) && tready;
            m_done = pop && head[DW];
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                if (m_beat == 0) m_mode = cfg_passthrough;
                if (outf) m_q.push_back({(m_beat == BEATS - 1), in_data});
                m_beat++;
                if (m_beat == BEATS) begin
                    m_beat = 0;
                    m_fidx = (m_fidx + 1) % NFR;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        tready   = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        done_seen = 0;
        m_beat = 0;
        m_fidx = 0;
        m_mode = 1'b0;
        m_done = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        cfg_passthrough = 1'b0;
        tready = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Group output: frame 0 dropped, frame 1 forwarded
        tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            step();
        end
        drain(3);

        // Backpressure during an output frame, then drain in order
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(32'h90 + i);
            step();
        end
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(32'hA0 + i);
            step();
        end
        drain(6);

        // Full FIFO with a simultaneous pop (passthrough keeps frames output)
        cfg_passthrough = 1'b1;
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(32'hB0 + i);
            step();
        end
        tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(32'hC0 + i);
            step();
        end
        drain(6);
        cfg_passthrough = 1'b0;

        // Passthrough raised mid-frame 0 only takes effect from the next frame
        rst = 1'b1;
        step();
        rst = 1'b0;
        done_seen = 0;
        tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) cfg_passthrough = 1'b1;
            in_valid = 1'b1;
            in_data  = DW'(32'hE0 + i);
            step();
        end
        drain(4);
        check("done_pulses", 64'(done_seen), 64'(2));
        cfg_passthrough = 1'b0;

        // Async reset with beats buffered and the counter at 3
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(32'hF0 + i);
            step();
        end
        in_valid = 1'b0;
        tready = 1'b1;
        step();
        tready = 1'b0;
        step();
        #1 rst = 1'b1;
        #1;
        check("rst_tvalid", 64'(tvalid), 64'(0));
        check("rst_tlast",  64'(tlast),  64'(0));
        check("rst_tdata",  64'(tdata),  64'(0));
        check("rst_done",   64'(done),   64'(0));
        check("rst_ready",  64'(in_ready), 64'(1));
        step();
        step();
        rst = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            step();
        end
        drain(3);

        // Stall stability: head must not move while tready is low
        cfg_passthrough = 1'b1;
        tready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'(32'hD1);
        step();
        in_data = DW'(32'hD2);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_tdata",  64'(tdata),  64'(32'hD1));
            check("stall_tvalid", 64'(tvalid), 64'(1));
            check("stall_tlast",  64'(tlast),  64'(0));
        end
        drain(4);
        cfg_passthrough = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = DW'($urandom);
            tready   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) cfg_passthrough = ~cfg_passthrough;
            step();
        end
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
